// File: rtl/decode_pkg.sv
// Shared types for the MIPS decode queue stage: opcode/funct encodings, instruction
// classes and the decoded entry that travels from decode to register-read.
package decode_pkg;

  // Address fields in a decoded entry are carried at this width. Narrower
  // ADDR_WIDTH builds zero-extend their addresses into these fields.
  localparam int DQ_ADDR_W = 32;

  localparam int INST_OP_HI  = 31;
  localparam int INST_OP_LO  = 26;
  localparam int INST_RS_HI  = 25;
  localparam int INST_RS_LO  = 21;
  localparam int INST_RT_HI  = 20;
  localparam int INST_RT_LO  = 16;
  localparam int INST_RD_HI  = 15;
  localparam int INST_RD_LO  = 11;
  localparam int INST_SH_HI  = 10;
  localparam int INST_SH_LO  = 6;
  localparam int INST_FN_HI  = 5;
  localparam int INST_FN_LO  = 0;
  localparam int INST_IMM_HI = 15;
  localparam int INST_IMM_LO = 0;
  localparam int INST_TGT_HI = 25;
  localparam int INST_TGT_LO = 0;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ORI     = 6'h0D,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_JR      = 6'h08,
    FN_SYSCALL = 6'h0C,
    FN_ADDU    = 6'h21,
    FN_SUBU    = 6'h23
  } funct_t;

  // CLS_NOP is zero so an all-zero entry reads as a harmless bubble.
  typedef enum logic [3:0] {
    CLS_NOP     = 4'd0,
    CLS_ADDU    = 4'd1,
    CLS_SUBU    = 4'd2,
    CLS_JR      = 4'd3,
    CLS_SYSCALL = 4'd4,
    CLS_ORI     = 4'd5,
    CLS_LUI     = 4'd6,
    CLS_LW      = 4'd7,
    CLS_SW      = 4'd8,
    CLS_BEQ     = 4'd9,
    CLS_BNE     = 4'd10,
    CLS_JAL     = 4'd11,
    CLS_ILLEGAL = 4'd12
  } inst_class_t;

  typedef logic [4:0]           register_id_t;
  typedef logic [DQ_ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t        pc;
    inst_class_t  cls;
    register_id_t rs;
    register_id_t rt;
    register_id_t rd;
    register_id_t destReg;
    logic         writesReg;
    logic [4:0]   shamt;
    logic [31:0]  extImm;
    addr_t        branchTarget;
    addr_t        jumpTarget;
    addr_t        linkValue;
    logic         illegal;
  } decoded_entry_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_queue_stage_if.sv
// Fetch-side and consumer-side handshake bundle of the decode queue stage.
// The stage itself connects through the slave modport.
interface decode_queue_stage_if
  import decode_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32
) ();

  // Both sides use plain valid/ready: a beat moves on a rising edge where valid
  // and ready are both high; a producer holds its payload until that edge, and
  // ready never waits on valid.
  logic                    inValid;
  logic                    inReady;
  logic [ADDR_WIDTH-1:0]   inPc;
  logic [31:0]             inInstruction;
  logic                    outValid;
  logic                    outReady;
  decoded_entry_t          outEntry;
  logic [$clog2(DEPTH):0]  occupancy;

  modport master (
    output inValid, inPc, inInstruction, outReady,
    input  inReady, outValid, outEntry, occupancy
  );

  modport slave (
    input  inValid, inPc, inInstruction, outReady,
    output inReady, outValid, outEntry, occupancy
  );

endinterface

// File: rtl/decode_queue_stage_fields.sv
// Combinational MIPS field splitter: {pc, instruction} -> decoded_entry_t.
// Define DECODE_QUEUE_ILLEGAL_TRAP_EN to tag unknown encodings as CLS_ILLEGAL.
module decode_fields
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [31:0]           instruction_i,
  output decoded_entry_t        entry_o
);

`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  opcode_t               op;
  funct_t                fn;
  logic [15:0]           imm;
  logic [25:0]           target;
  register_id_t          rs, rt, rd;
  inst_class_t           cls;
  logic                  unknown;
  register_id_t          dest;
  logic [31:0]           ext_imm;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] link_value;

  assign op     = opcode_t'(instruction_i[INST_OP_HI:INST_OP_LO]);
  assign fn     = funct_t'(instruction_i[INST_FN_HI:INST_FN_LO]);
  assign imm    = instruction_i[INST_IMM_HI:INST_IMM_LO];
  assign target = instruction_i[INST_TGT_HI:INST_TGT_LO];
  assign rs     = instruction_i[INST_RS_HI:INST_RS_LO];
  assign rt     = instruction_i[INST_RT_HI:INST_RT_LO];
  assign rd     = instruction_i[INST_RD_HI:INST_RD_LO];

  always_comb begin
    cls     = CLS_NOP;
    unknown = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU:    cls = CLS_ADDU;
          FN_SUBU:    cls = CLS_SUBU;
          FN_JR:      cls = CLS_JR;
          FN_SYSCALL: cls = CLS_SYSCALL;
          default:    unknown = 1'b1;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_JAL:  cls = CLS_JAL;
      default: unknown = 1'b1;
    endcase
    if (unknown && TRAP_EN) begin
      cls = CLS_ILLEGAL;
    end
  end

  always_comb begin
    ext_imm = 32'h0;
    dest    = '0;
    case (cls)
      CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE: ext_imm = sign_ext16(imm);
      CLS_ORI:                          ext_imm = {16'h0, imm};
      CLS_LUI:                          ext_imm = {imm, 16'h0};
      default:                          ext_imm = 32'h0;
    endcase
    case (cls)
      CLS_ADDU, CLS_SUBU:         dest = rd;
      CLS_ORI, CLS_LUI, CLS_LW:   dest = rt;
      CLS_JAL:                    dest = 5'd31;
      default:                    dest = '0;
    endcase
  end

  // Target arithmetic wraps at ADDR_WIDTH bits before being widened into the entry.
  assign pc_plus4      = pc_i + ADDR_WIDTH'(4);
  assign branch_target = pc_plus4 + {{(ADDR_WIDTH-18){imm[15]}}, imm, 2'b00};
  assign link_value    = (cls == CLS_JAL) ? pc_i + ADDR_WIDTH'(8) : '0;

  generate
    if (ADDR_WIDTH > 28) begin : g_jump_upper
      assign jump_target = {pc_plus4[ADDR_WIDTH-1:28], target, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {target, 2'b00};
    end
  endgenerate

  always_comb begin
    entry_o              = '0;
    entry_o.pc           = addr_t'(pc_i);
    entry_o.cls          = cls;
    entry_o.rs           = rs;
    entry_o.rt           = rt;
    entry_o.rd           = rd;
    entry_o.destReg      = dest;
    entry_o.writesReg    = (dest != '0);
    entry_o.shamt        = instruction_i[INST_SH_HI:INST_SH_LO];
    entry_o.extImm       = ext_imm;
    entry_o.branchTarget = addr_t'(branch_target);
    entry_o.jumpTarget   = addr_t'(jump_target);
    entry_o.linkValue    = addr_t'(link_value);
    entry_o.illegal      = (cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Registered MIPS decode stage: decodes fetch beats and buffers them in a DEPTH-entry
// FIFO ahead of register-read. Optional macro: DECODE_QUEUE_ILLEGAL_TRAP_EN.
module decode_queue_stage
  import decode_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  flush,
  decode_queue_stage_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decoded_entry_t  mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  decoded_entry_t  dec_entry;
  logic            push, pop;

  decode_fields #(.ADDR_WIDTH(ADDR_WIDTH)) u_fields (
    .pc_i          (bus.inPc),
    .instruction_i (bus.inInstruction),
    .entry_o       (dec_entry)
  );

  // inReady looks only at occupancy, so a full queue never passes a beat through.
  assign bus.inReady   = (count_q != CW'(DEPTH));
  assign bus.outValid  = (count_q != '0);
  assign bus.outEntry  = bus.outValid ? mem_q[rd_ptr_q] : '0;
  assign bus.occupancy = count_q;

  assign push = bus.inValid  && bus.inReady  && !flush;
  assign pop  = bus.outValid && bus.outReady && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty queue masks it from outEntry.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec_entry;
    end
  end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage (DEPTH=4): decode values, full/stall,
// steady push+pop, flush, unknown encodings and asynchronous reset.
module tb_decode_queue_stage;
  import decode_pkg::*;

  localparam int DEPTH      = 4;
  localparam int ADDR_WIDTH = 32;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  logic flush  = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  decode_queue_stage_if #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  decode_queue_stage #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock  (clock),
    .resetN (resetN),
    .flush  (flush),
    .bus    (bus.slave)
  );

  decoded_entry_t e;
  assign e = bus.outEntry;

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    bus.inValid       = 1'b0;
    bus.inPc          = '0;
    bus.inInstruction = '0;
    bus.outReady      = 1'b0;
    flush             = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] word);
    bus.inValid       = 1'b1;
    bus.inPc          = pc;
    bus.inInstruction = word;
  endtask

  initial begin
    logic [31:0] words [4];
    logic [4:0]  dests [4];
    logic [31:0] exts  [4];
    logic [3:0]  clss  [4];
    words = '{32'h00221821, 32'h00222023, 32'h3425F0F0, 32'h8C26FFFC};
    dests = '{5'd3, 5'd4, 5'd5, 5'd6};
    exts  = '{32'h0, 32'h0, 32'h0000F0F0, 32'hFFFFFFFC};
    clss  = '{CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LW};

    idle();
    repeat (2) @(negedge clock);
    chk("reset_in_ready", 32'(bus.inReady), 32'd1);
    resetN = 1'b1;
    tick();
    chk("reset_out_valid", 32'(bus.outValid), 32'd0);
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset_entry_pc", e.pc, 32'h0);
    chk("reset_entry_imm", e.extImm, 32'h0);

    // LUI $1, 0x1234
    present(32'h00400000, 32'h3C011234);
    tick();
    idle();
    chk("lui_valid", 32'(bus.outValid), 32'd1);
    chk("lui_cls", 32'(e.cls), 32'(CLS_LUI));
    chk("lui_dest", 32'(e.destReg), 32'd1);
    chk("lui_writes", 32'(e.writesReg), 32'd1);
    chk("lui_imm", e.extImm, 32'h12340000);
    chk("lui_branch", e.branchTarget, 32'h004048D4);
    chk("lui_jump", e.jumpTarget, 32'h000448D0);
    chk("lui_link", e.linkValue, 32'h0);
    bus.outReady = 1'b1;
    tick();
    idle();
    chk("lui_drained", 32'(bus.outValid), 32'd0);

    // Fill with consumer stalled, then offer one more beat.
    for (int i = 0; i < DEPTH; i++) begin
      present(32'h00400100 + 32'(4 * i), words[i]);
      tick();
    end
    idle();
    chk("full_ready", 32'(bus.inReady), 32'd0);
    chk("full_occ", 32'(bus.occupancy), 32'd4);
    present(32'h00400200, 32'hAC270000);
    tick();
    idle();
    chk("full_extra_occ", 32'(bus.occupancy), 32'd4);
    tick();
    chk("stall_head_pc", e.pc, 32'h00400100);
    chk("stall_head_cls", 32'(e.cls), 32'(CLS_ADDU));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc", e.pc, 32'h00400100 + 32'(4 * i));
      chk("drain_cls", 32'(e.cls), 32'(clss[i]));
      chk("drain_dest", 32'(e.destReg), 32'(dests[i]));
      chk("drain_imm", e.extImm, exts[i]);
      bus.outReady = 1'b1;
      tick();
      idle();
    end
    chk("drain_empty", 32'(bus.outValid), 32'd0);
    chk("drain_ready", 32'(bus.inReady), 32'd1);

    // Steady push+pop at occupancy 1 long enough to wrap both pointers.
    present(32'h00500000, 32'h34250000);
    exp_q.push_back(32'h00500000);
    tick();
    for (int k = 1; k <= 10; k++) begin
      present(32'h00500000 + 32'(4 * k), 32'h34250000 | 32'(k));
      bus.outReady = 1'b1;
      chk("steady_occ", 32'(bus.occupancy), 32'd1);
      chk("steady_pc", e.pc, exp_q[0]);
      chk("steady_imm", e.extImm, 32'(k - 1));
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h00500000 + 32'(4 * k));
    end
    idle();
    chk("steady_final_occ", 32'(bus.occupancy), 32'd1);
    chk("steady_final_pc", e.pc, 32'h00500028);
    chk("steady_final_imm", e.extImm, 32'd10);
    bus.outReady = 1'b1;
    tick();
    idle();
    void'(exp_q.pop_front());
    chk("steady_empty", 32'(bus.outValid), 32'd0);

    // BEQ backwards-by-one and JAL targets.
    present(32'h00400010, 32'h1000FFFF);
    tick();
    present(32'h00400000, 32'h0C100000);
    tick();
    idle();
    chk("beq_cls", 32'(e.cls), 32'(CLS_BEQ));
    chk("beq_branch", e.branchTarget, 32'h00400010);
    chk("beq_imm", e.extImm, 32'hFFFFFFFF);
    chk("beq_writes", 32'(e.writesReg), 32'd0);
    bus.outReady = 1'b1;
    tick();
    idle();
    chk("jal_cls", 32'(e.cls), 32'(CLS_JAL));
    chk("jal_jump", e.jumpTarget, 32'h00400000);
    chk("jal_dest", 32'(e.destReg), 32'd31);
    chk("jal_writes", 32'(e.writesReg), 32'd1);
    chk("jal_link", e.linkValue, 32'h00400008);
    bus.outReady = 1'b1;
    tick();
    idle();

    // Flush with a same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      present(32'h00600000 + 32'(4 * i), 32'h00221821);
      tick();
    end
    idle();
    chk("preflush_occ", 32'(bus.occupancy), 32'd3);
    flush = 1'b1;
    bus.outReady = 1'b1;
    present(32'h0060000C, 32'h00222023);
    tick();
    idle();
    chk("flush_occ", 32'(bus.occupancy), 32'd0);
    chk("flush_valid", 32'(bus.outValid), 32'd0);
    chk("flush_ready", 32'(bus.inReady), 32'd1);
    tick();
    chk("flush_no_ghost", 32'(bus.outValid), 32'd0);
    present(32'h00600100, 32'h3C011234);
    tick();
    idle();
    chk("postflush_pc", e.pc, 32'h00600100);
    chk("postflush_occ", 32'(bus.occupancy), 32'd1);
    bus.outReady = 1'b1;
    tick();
    idle();

    // Unknown opcode 0x3F.
    present(32'h00400200, 32'hFC000000);
    tick();
    idle();
`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
    chk("unk_cls", 32'(e.cls), 32'(CLS_ILLEGAL));
    chk("unk_illegal", 32'(e.illegal), 32'd1);
`else
    chk("unk_cls", 32'(e.cls), 32'(CLS_NOP));
    chk("unk_illegal", 32'(e.illegal), 32'd0);
`endif
    chk("unk_writes", 32'(e.writesReg), 32'd0);
    chk("unk_dest", 32'(e.destReg), 32'd0);
    chk("unk_pc", e.pc, 32'h00400200);

    // Asynchronous reset between clock edges with entries queued.
    present(32'h00400204, 32'h3C011234);
    tick();
    chk("prereset_occ", 32'(bus.occupancy), 32'd2);
    #1 resetN = 1'b0;
    #1;
    chk("areset_valid", 32'(bus.outValid), 32'd0);
    chk("areset_occ", 32'(bus.occupancy), 32'd0);
    chk("areset_pc", e.pc, 32'h0);
    chk("areset_ready", 32'(bus.inReady), 32'd1);
    @(negedge clock);
    idle();
    resetN = 1'b1;
    tick();
    chk("postreset_valid", 32'(bus.outValid), 32'd0);
    chk("postreset_occ", 32'(bus.occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
